// File: rtl/rvfi_retire_buffer.sv
// RVFI retirement-stream checker with a first-word-fall-through record FIFO.
// Every valid record is checked. Records that fit in the FIFO drain over a valid/ready port.
module rvfi_retire_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rvfi_valid,
    input  logic [63:0]   rvfi_order,
    input  logic [31:0]   rvfi_insn,
    input  logic          rvfi_trap,
    input  logic          rvfi_halt,
    input  logic          rvfi_intr,
    input  logic [4:0]    rvfi_rd_addr,
    input  logic [31:0]   rvfi_rd_wdata,
    input  logic [31:0]   rvfi_pc_rdata,
    input  logic [31:0]   rvfi_pc_wdata,
    input  logic [31:0]   rvfi_mem_addr,
    input  logic [31:0]   rvfi_mem_rdata,
    input  logic [31:0]   rvfi_mem_wdata,
    input  logic [3:0]    rvfi_mem_rmask,
    input  logic [3:0]    rvfi_mem_wmask,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_order,
    output logic [31:0]   out_insn,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_next_pc,
    output logic [31:0]   out_rd_wdata,
    output logic [31:0]   out_mem_addr,
    output logic [31:0]   out_mem_rdata,
    output logic [31:0]   out_mem_wdata,
    output logic [4:0]    out_rd_addr,
    output logic [3:0]    out_rmask,
    output logic [3:0]    out_wmask,
    output logic [2:0]    out_flags,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_count,
    output logic          err_order,
    output logic          err_pc,
    output logic          err_x0,
    output logic          err_post_halt,
    output logic [63:0]   first_err_order,
    output logic          halted
);
    localparam int W = 304;
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_count;
    logic [63:0]   r_exp_order;
    logic [31:0]   r_prev_pc;
    logic          r_have_prev;
    logic          r_err_order;
    logic          r_err_pc;
    logic          r_err_x0;
    logic          r_err_post_halt;
    logic [63:0]   r_first_err_order;
    logic          r_halted;

    logic [W-1:0]  w_rec_in;
    logic [W-1:0]  w_head;
    logic          w_pop;
    logic          w_full;
    logic          w_accept;
    logic          w_drop;
    logic [AW:0]   w_count_next;
    logic          w_chk_order;
    logic          w_chk_pc;
    logic          w_chk_x0;
    logic          w_chk_halt;

    assign w_rec_in = {rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata,
                       rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_rd_addr,
                       rvfi_mem_rmask, rvfi_mem_wmask, rvfi_trap, rvfi_halt, rvfi_intr};

    // A full FIFO still takes a record when the head leaves in the same cycle.
    assign w_pop    = out_valid && out_ready;
    assign w_full   = (r_count == L_FULL);
    assign w_accept = rvfi_valid && (!w_full || w_pop);
    assign w_drop   = rvfi_valid && !w_accept;

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_accept && w_pop)
            w_count_next = r_count - 1'b1;
    end

    assign w_chk_order = rvfi_valid && (rvfi_order != r_exp_order);
    assign w_chk_pc    = rvfi_valid && r_have_prev && !rvfi_intr && (rvfi_pc_rdata != r_prev_pc);
    assign w_chk_x0    = rvfi_valid && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
    assign w_chk_halt  = rvfi_valid && r_halted;

    always_ff @(posedge clk) begin
        if (!reset && w_accept)
            r_mem[r_wr_ptr] <= w_rec_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF)
                    r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Checks run on every valid record, including ones the FIFO drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_order       <= 64'd0;
            r_prev_pc         <= 32'd0;
            r_have_prev       <= 1'b0;
            r_err_order       <= 1'b0;
            r_err_pc          <= 1'b0;
            r_err_x0          <= 1'b0;
            r_err_post_halt   <= 1'b0;
            r_first_err_order <= 64'd0;
            r_halted          <= 1'b0;
        end else if (rvfi_valid) begin
            r_exp_order <= rvfi_order + 64'd1;
            r_prev_pc   <= rvfi_pc_wdata;
            r_have_prev <= 1'b1;
            if (w_chk_order) r_err_order     <= 1'b1;
            if (w_chk_pc)    r_err_pc        <= 1'b1;
            if (w_chk_x0)    r_err_x0        <= 1'b1;
            if (w_chk_halt)  r_err_post_halt <= 1'b1;
            if (rvfi_halt)   r_halted        <= 1'b1;
            if (!(r_err_order || r_err_pc || r_err_x0 || r_err_post_halt) &&
                (w_chk_order || w_chk_pc || w_chk_x0 || w_chk_halt))
                r_first_err_order <= rvfi_order;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign out_valid       = (r_count != '0);
    assign out_order       = w_head[303:240];
    assign out_insn        = w_head[239:208];
    assign out_pc          = w_head[207:176];
    assign out_next_pc     = w_head[175:144];
    assign out_rd_wdata    = w_head[143:112];
    assign out_mem_addr    = w_head[111:80];
    assign out_mem_rdata   = w_head[79:48];
    assign out_mem_wdata   = w_head[47:16];
    assign out_rd_addr     = w_head[15:11];
    assign out_rmask       = w_head[10:7];
    assign out_wmask       = w_head[6:3];
    assign out_flags       = w_head[2:0];
    assign count           = r_count;
    assign overflow        = r_overflow;
    assign drop_count      = r_drop_count;
    assign err_order       = r_err_order;
    assign err_pc          = r_err_pc;
    assign err_x0          = r_err_x0;
    assign err_post_halt   = r_err_post_halt;
    assign first_err_order = r_first_err_order;
    assign halted          = r_halted;
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Directed bench for rvfi_retire_buffer: stream order, checks, overflow and reset.
module tb_rvfi_retire_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        out_valid, out_ready;
    logic [63:0] out_order;
    logic [31:0] out_insn, out_pc, out_next_pc, out_rd_wdata, out_mem_addr, out_mem_rdata, out_mem_wdata;
    logic [4:0]  out_rd_addr;
    logic [3:0]  out_rmask, out_wmask;
    logic [2:0]  out_flags;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        err_order, err_pc, err_x0, err_post_halt;
    logic [63:0] first_err_order;
    logic        halted;

    int n_cmp = 0;
    int n_mis = 0;

    rvfi_retire_buffer #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
        .out_insn(out_insn), .out_pc(out_pc), .out_next_pc(out_next_pc),
        .out_rd_wdata(out_rd_wdata), .out_mem_addr(out_mem_addr),
        .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
        .out_rd_addr(out_rd_addr), .out_rmask(out_rmask), .out_wmask(out_wmask),
        .out_flags(out_flags), .count(count), .overflow(overflow),
        .drop_count(drop_count), .err_order(err_order), .err_pc(err_pc),
        .err_x0(err_x0), .err_post_halt(err_post_halt),
        .first_err_order(first_err_order), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one record for one cycle; returns 1 time unit after the capturing edge.
    task automatic send(input logic [63:0] ord, input logic [31:0] pcr, input logic [31:0] pcw,
                        input logic [4:0] rd, input logic [31:0] rdw, input logic [2:0] fl);
        rvfi_order     = ord;
        rvfi_insn      = 32'hA000_0000 | ord[31:0];
        rvfi_pc_rdata  = pcr;
        rvfi_pc_wdata  = pcw;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = rdw;
        {rvfi_trap, rvfi_halt, rvfi_intr} = fl;
        rvfi_mem_addr  = 32'h1000 + ord[31:0];
        rvfi_mem_rdata = ~ord[31:0];
        rvfi_mem_wdata = ord[31:0] * 3;
        rvfi_mem_rmask = ord[3:0];
        rvfi_mem_wmask = ~ord[3:0];
        rvfi_valid     = 1'b1;
        @(posedge clk);
        #1;
        rvfi_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_errs(input string tag, input logic [3:0] exp);
        chk(tag, {err_order, err_pc, err_x0, err_post_halt}, exp);
    endtask

    logic [63:0] exp_ord;

    initial begin
        reset = 1'b1; out_ready = 1'b0; rvfi_valid = 1'b0;
        rvfi_order = '0; rvfi_insn = '0; rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0;
        rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
        rvfi_mem_addr = '0; rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
        rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        chk_errs("rst_errs", 4'b0000);
        chk("rst_first_err", first_err_order, 0);
        chk("rst_halted", halted, 0);

        // Five in-order records streamed with the consumer always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(64'(k), 32'(4*k), 32'(4*k+4), 5'(k+1), 32'hDEAD_0000 + 32'(k), 3'b000);
            $display("t1 rec %0d: head order %0d pc %0h count %0d", k, out_order, out_pc, count);
            chk("t1_valid", out_valid, 1);
            chk("t1_order", out_order, 64'(k));
            chk("t1_pc", out_pc, 64'(4*k));
            chk("t1_next_pc", out_next_pc, 64'(4*k+4));
            chk("t1_insn", out_insn, 64'(32'hA000_0000 + 32'(k)));
            chk("t1_rd", {out_rd_addr, out_rd_wdata}, {5'(k+1), 32'hDEAD_0000 + 32'(k)});
            chk("t1_mem", {out_mem_addr, out_mem_rdata},
                {32'h1000 + 32'(k), ~(32'(k))});
            chk("t1_mem_wdata", out_mem_wdata, 64'(3*k));
            chk("t1_masks", {out_rmask, out_wmask, out_flags}, {4'(k), ~(4'(k)), 3'b000});
            chk("t1_count", count, 1);
        end
        @(posedge clk);
        #1;
        chk("t1_drained_count", count, 0);
        chk("t1_drained_valid", out_valid, 0);
        chk_errs("t1_errs", 4'b0000);

        // Order skip: one error on the skip, resynchronised afterwards.
        do_reset();
        send(64'd0, 32'h0, 32'h4, 5'd1, 32'd1, 3'b000);
        send(64'd1, 32'h4, 32'h8, 5'd1, 32'd1, 3'b000);
        chk_errs("t2_before_skip", 4'b0000);
        send(64'd3, 32'h8, 32'hC, 5'd1, 32'd1, 3'b000);
        $display("t2 skip: err_order %0d first_err_order %0d", err_order, first_err_order);
        chk_errs("t2_skip_errs", 4'b1000);
        chk("t2_first_err", first_err_order, 3);
        chk("t2_head", out_order, 3);
        send(64'd4, 32'hC, 32'h10, 5'd1, 32'd1, 3'b000);
        chk_errs("t2_after_errs", 4'b1000);
        chk("t2_first_err_kept", first_err_order, 3);

        // PC discontinuity without and with interrupt.
        do_reset();
        send(64'd0, 32'h0, 32'h100, 5'd1, 32'd1, 3'b000);
        chk_errs("t3_first_rec", 4'b0000);
        send(64'd1, 32'h200, 32'h204, 5'd1, 32'd1, 3'b000);
        $display("t3 pc break: err_pc %0d", err_pc);
        chk_errs("t3_pc_break", 4'b0100);
        chk("t3_first_err", first_err_order, 1);
        do_reset();
        send(64'd0, 32'h0, 32'h100, 5'd1, 32'd1, 3'b000);
        send(64'd1, 32'h200, 32'h204, 5'd1, 32'd1, 3'b001);
        $display("t3 intr: err_pc %0d", err_pc);
        chk_errs("t3_intr_exempt", 4'b0000);
        send(64'd2, 32'h204, 32'h208, 5'd1, 32'd1, 3'b000);
        chk_errs("t3_intr_reload", 4'b0000);

        // Overflow with the consumer stalled, then push+pop on a full FIFO.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send(64'(k), 32'(4*k), 32'(4*k+4), 5'd1, 32'(k), 3'b000);
            if (k == 15) begin
                chk("t4_full_count", count, 16);
                chk("t4_full_no_ovf", overflow, 0);
            end
        end
        $display("t4 overflow: count %0d overflow %0d drops %0d", count, overflow, drop_count);
        chk("t4_count", count, 16);
        chk("t4_overflow", overflow, 1);
        chk("t4_drop_count", drop_count, 4);
        chk("t4_head_stable", out_order, 0);
        chk_errs("t4_errs", 4'b0000);
        out_ready = 1'b1;
        send(64'd20, 32'd80, 32'd84, 5'd1, 32'd20, 3'b000);
        chk("t4_pp_count", count, 16);
        chk("t4_pp_drop_count", drop_count, 4);
        chk("t4_pp_head", out_order, 1);
        chk_errs("t4_pp_errs", 4'b0000);
        for (int i = 0; i < 16; i++) begin
            exp_ord = (i < 15) ? 64'(i + 1) : 64'd20;
            $display("t4 drain %0d: head order %0d", i, out_order);
            chk("t4_drain_valid", out_valid, 1);
            chk("t4_drain_order", out_order, exp_ord);
            @(posedge clk);
            #1;
        end
        chk("t4_empty_count", count, 0);
        chk("t4_empty_valid", out_valid, 0);

        // x0 write, halt, then retirement after halt.
        do_reset();
        send(64'd0, 32'h0, 32'h4, 5'd1, 32'd1, 3'b000);
        send(64'd1, 32'h4, 32'h8, 5'd0, 32'd5, 3'b000);
        $display("t5 x0: err_x0 %0d first_err_order %0d", err_x0, first_err_order);
        chk_errs("t5_x0", 4'b0010);
        chk("t5_first_err", first_err_order, 1);
        send(64'd2, 32'h8, 32'hC, 5'd1, 32'd1, 3'b010);
        chk("t5_halted", halted, 1);
        chk("t5_halt_flags", out_flags, 3'b010);
        chk_errs("t5_halt_no_err", 4'b0010);
        send(64'd3, 32'hC, 32'h10, 5'd1, 32'd1, 3'b000);
        $display("t5 post halt: err_post_halt %0d", err_post_halt);
        chk_errs("t5_post_halt", 4'b0011);
        chk("t5_first_err_kept", first_err_order, 1);

        // Several errors in one record.
        do_reset();
        send(64'd5, 32'h0, 32'h4, 5'd0, 32'd7, 3'b000);
        chk_errs("t5_multi", 4'b1010);
        chk("t5_multi_first", first_err_order, 5);

        // Reset mid-stream with a record presented in the reset cycle.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++)
            send(64'(k), 32'(4*k), 32'(4*k+4), (k == 6) ? 5'd0 : 5'd1, 32'(k),
                 (k == 6) ? 3'b010 : 3'b000);
        chk("t6_count", count, 7);
        chk("t6_halted", halted, 1);
        chk_errs("t6_errs", 4'b0010);
        rvfi_order = 64'd99;
        rvfi_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rvfi_valid = 1'b0;
        $display("t6 reset: out_valid %0d count %0d", out_valid, count);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", count, 0);
        chk_errs("t6_rst_errs", 4'b0000);
        chk("t6_rst_halted", halted, 0);
        chk("t6_rst_first", first_err_order, 0);
        chk("t6_rst_ovf", {overflow, drop_count}, 0);
        out_ready = 1'b1;
        send(64'd0, 32'h40, 32'h44, 5'd1, 32'd1, 3'b000);
        chk_errs("t6_after_errs", 4'b0000);
        chk("t6_after_count", count, 1);
        chk("t6_after_order", out_order, 0);
        chk("t6_after_pc", out_pc, 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
